pf_iod_generic_tx_training_gen: RTL and testbench

Transmit-side companion to the generic RX IOD clock-training lane. Drives the 8-bit parallel word into a TX IOD serializer (`TX_DATA_0`). After reset, or on request, it sends a fixed clock-like training pattern so the far-end receiver's eye monitor and delay line can centre, then a short sync preamble, then user payload. It also owns the `TX_SYNC_RST` pulse for the local TX IOD lane.

---
 rtl/pf_iod_generic_tx_training_gen.sv | 73 +++++++
 tb/tb_pf_iod_generic_tx_training_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pf_iod_generic_tx_training_gen.sv
// pf_iod_generic_tx_training_gen: TX IOD word source that sends a training burst, then a sync preamble, then payload.
//   FAB_CLK       fabric clock (same as TX IOD TX_CLK)
//   ARST_N        asynchronous active-low reset
//   TRAIN_REQ     one-cycle pulse restarting a training pass (ignored in RESET_HOLD)
//   TX_DATA_IN    payload word, accepted when TX_VALID_IN && TX_READY
//   TX_VALID_IN   payload valid
//   TX_READY      combinational copy of LINK_UP
//   TX_DATA_0     registered word to the TX IOD serializer
//   TX_SYNC_RST   TX IOD lane sync reset, high only in reset and RESET_HOLD
//   TRAINING_BUSY high in RESET_HOLD, TRAIN and SYNC
//   LINK_UP       high in DATA
module pf_iod_generic_tx_training_gen #(
  parameter logic [7:0] TRAIN_WORD = 8'b00001111,
  parameter logic [7:0] SYNC_WORD = 8'h5C,
  parameter logic [7:0] IDLE_WORD = 8'h00,
  parameter int TRAIN_LEN = 1024,
  parameter int SYNC_LEN = 4,
  parameter int RST_HOLD_CYCLES = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRAIN_REQ,
  input  logic [7:0] TX_DATA_IN,
  input  logic       TX_VALID_IN,
  output logic       TX_READY,
  output logic [7:0] TX_DATA_0,
  output logic       TX_SYNC_RST,
  output logic       TRAINING_BUSY,
  output logic       LINK_UP
);
  typedef enum logic [1:0] {RESET_HOLD, TRAIN, SYNC, DATA} state_t;
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN - 1);
  state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [7:0] data_d;
  logic accept, done, restart;
  assign TX_READY = LINK_UP;
  always_comb begin
    accept = TX_VALID_IN && TX_READY;
    restart = TRAIN_REQ && state != RESET_HOLD;
    done = state == RESET_HOLD ? cnt == HOLD_LAST :
           state == TRAIN ? cnt == TRAIN_LAST :
           state == SYNC ? cnt == SYNC_LAST : 1'b0;
    state_d = restart ? TRAIN :
              !done ? state :
              state == RESET_HOLD ? TRAIN :
              state == TRAIN ? SYNC : DATA;
    // Cleared on every state entry (including a retrain into TRAIN); saturates so it never wraps in DATA.
    cnt_d = (restart || state_d != state) ? 16'd0 : (&cnt ? cnt : cnt + 16'd1);
    data_d = state == TRAIN ? TRAIN_WORD :
             state == SYNC ? SYNC_WORD :
             state == DATA ? (accept ? TX_DATA_IN : IDLE_WORD) : 8'h00;
  end
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state <= RESET_HOLD;
      cnt <= 16'd0;
      TX_DATA_0 <= 8'h00;
      TX_SYNC_RST <= 1'b1;
      TRAINING_BUSY <= 1'b1;
      LINK_UP <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      TX_DATA_0 <= data_d;
      TX_SYNC_RST <= state_d == RESET_HOLD;
      TRAINING_BUSY <= state_d != DATA;
      LINK_UP <= state_d == DATA;
    end
  end
endmodule

// File: tb/tb_pf_iod_generic_tx_training_gen.sv
// tb_pf_iod_generic_tx_training_gen: directed bench for the TX training generator with default parameters.
module tb_pf_iod_generic_tx_training_gen;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic train_req = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic tx_valid_in = 1'b0;
  logic tx_ready;
  logic [7:0] tx_data_0;
  logic tx_sync_rst;
  logic training_busy;
  logic link_up;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pf_iod_generic_tx_training_gen dut (
    .FAB_CLK(clk),
    .ARST_N(arst_n),
    .TRAIN_REQ(train_req),
    .TX_DATA_IN(tx_data_in),
    .TX_VALID_IN(tx_valid_in),
    .TX_READY(tx_ready),
    .TX_DATA_0(tx_data_0),
    .TX_SYNC_RST(tx_sync_rst),
    .TRAINING_BUSY(training_busy),
    .LINK_UP(link_up)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_run(input string tag, input logic [7:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      check(tag, tx_data_0, word);
      check({tag, "_sync_rst"}, {7'd0, tx_sync_rst}, 8'd0);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, tx_data_0, 8'h00);
    check({tag, "_sync_rst"}, {7'd0, tx_sync_rst}, 8'd1);
    check({tag, "_busy"}, {7'd0, training_busy}, 8'd1);
    check({tag, "_link"}, {7'd0, link_up}, 8'd0);
    check({tag, "_ready"}, {7'd0, tx_ready}, 8'd0);
  endtask
  // Edges numbered from the first rising edge after release.
  task automatic bringup(input string tag);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      check({tag, "_hold_sync_rst"}, {7'd0, tx_sync_rst}, (k < 4) ? 8'd1 : 8'd0);
      check({tag, "_hold_data"}, tx_data_0, 8'h00);
      check({tag, "_hold_busy"}, {7'd0, training_busy}, 8'd1);
    end
    expect_run({tag, "_train"}, 8'h0F, 1024);
    expect_run({tag, "_sync"}, 8'h5C, 3);
    check({tag, "_link_before_last_sync"}, {7'd0, link_up}, 8'd0);
    expect_run({tag, "_sync_last"}, 8'h5C, 1);
    check({tag, "_link_up"}, {7'd0, link_up}, 8'd1);
    check({tag, "_busy_low"}, {7'd0, training_busy}, 8'd0);
    check({tag, "_ready"}, {7'd0, tx_ready}, 8'd1);
    tick;
    check({tag, "_idle"}, tx_data_0, 8'h00);
  endtask
  initial begin
    #12;
    check_reset_outputs("por");
    bringup("boot");
    for (int i = 1; i <= 16; i++) begin
      tx_valid_in = 1'b1;
      tx_data_in = 8'(i);
      tick;
      check("stream", tx_data_0, 8'(i));
    end
    tx_valid_in = 1'b0;
    tick;
    check("stream_end_idle", tx_data_0, 8'h00);
    tx_valid_in = 1'b1;
    tx_data_in = 8'hA5;
    tick;
    check("idle_ins_a5", tx_data_0, 8'hA5);
    tx_valid_in = 1'b0;
    tx_data_in = 8'hFF;
    tick;
    check("idle_ins_gap", tx_data_0, 8'h00);
    tx_valid_in = 1'b1;
    tx_data_in = 8'h3C;
    tick;
    check("idle_ins_3c", tx_data_0, 8'h3C);
    tx_data_in = 8'h77;
    train_req = 1'b1;
    check("retrain_ready_same_cycle", {7'd0, tx_ready}, 8'd1);
    tick;
    train_req = 1'b0;
    tx_valid_in = 1'b0;
    check("retrain_beat", tx_data_0, 8'h77);
    check("retrain_ready_drop", {7'd0, tx_ready}, 8'd0);
    check("retrain_busy", {7'd0, training_busy}, 8'd1);
    check("retrain_link", {7'd0, link_up}, 8'd0);
    check("retrain_sync_rst", {7'd0, tx_sync_rst}, 8'd0);
    expect_run("retrain_train", 8'h0F, 1024);
    expect_run("retrain_sync", 8'h5C, 4);
    check("retrain_link_up", {7'd0, link_up}, 8'd1);
    train_req = 1'b1;
    tick;
    train_req = 1'b0;
    check("req2_idle", tx_data_0, 8'h00);
    expect_run("mid_train_first", 8'h0F, 500);
    train_req = 1'b1;
    expect_run("mid_train_req_beat", 8'h0F, 1);
    train_req = 1'b0;
    expect_run("mid_train_restart", 8'h0F, 1024);
    expect_run("mid_train_sync", 8'h5C, 4);
    check("mid_train_link", {7'd0, link_up}, 8'd1);
    train_req = 1'b1;
    tick;
    train_req = 1'b0;
    expect_run("pre_arst_train", 8'h0F, 1024);
    expect_run("pre_arst_sync", 8'h5C, 2);
    check("pre_arst_sync_rst", {7'd0, tx_sync_rst}, 8'd0);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bringup("rebooted");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
